// File: rtl/melody_if.sv
// Problem-interface bundle between the keypad/game side and melody_writer.
// Signal prefixes are from the writer's point of view: i_ into it, o_ out of it.
interface melody_if;
    logic        i_arm;
    logic        i_key_valid;
    logic [3:0]  i_key_code;
    logic        i_clear;
    logic        i_rand_fill;
    logic        i_game_end;
    logic [31:0] o_data_out;
    logic        o_write_enable;
    logic        o_game_start;
    logic [3:0]  o_echo_out;
    logic [3:0]  o_note_count;
    logic        o_busy;

    modport master (
        output i_arm, i_key_valid, i_key_code, i_clear, i_rand_fill, i_game_end,
        input  o_data_out, o_write_enable, o_game_start, o_echo_out, o_note_count, o_busy
    );

    modport slave (
        input  i_arm, i_key_valid, i_key_code, i_clear, i_rand_fill, i_game_end,
        output o_data_out, o_write_enable, o_game_start, o_echo_out, o_note_count, o_busy
    );
endinterface

// File: rtl/melody_writer.sv
// Melody problem producer: records keypad notes (or a random fill when MELODY_RANDOM_EN
// is defined), packs them into a 32-bit word, strobes write then game start, awaits game end.
module melody_writer #(
    parameter int NUM_NOTES   = 8,
    parameter int START_GAP   = 16,
    parameter int ECHO_CYCLES = 2500000
) (
    input  logic    clk,
    input  logic    reset,
    melody_if.slave bus
);
    localparam int                GAP_W     = $clog2(START_GAP + 1);
    localparam int                ECHO_W    = $clog2(ECHO_CYCLES + 1);
    localparam logic [3:0]        LAST_SLOT = 4'(NUM_NOTES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(START_GAP - 1);
    localparam logic [ECHO_W-1:0] ECHO_LOAD = ECHO_W'(ECHO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECORD,
        S_FILL,
        S_WRITE,
        S_GAP,
        S_START,
        S_WAIT_END
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_data;
    logic [3:0]          r_count;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [3:0]          r_echo;
    logic [ECHO_W-1:0]   r_echo_cnt;

    logic                w_key_ok;
    logic [2:0]          w_note;
    logic                w_fill_req;
    logic                w_clear_word;
    logic                w_store;
    logic [2:0]          w_store_val;
    logic                w_echo_load;
    logic                w_echo_cancel;
    logic                w_write_enable;
    logic                w_game_start;
    logic                w_busy;

    assign w_key_ok = bus.i_key_valid && (bus.i_key_code >= 4'd1) && (bus.i_key_code <= 4'd8);
    assign w_note   = 3'(bus.i_key_code - 4'd1);

`ifdef MELODY_RANDOM_EN
    logic [15:0] r_lfsr;

    // Fibonacci taps 16,14,13,11 in right-shift form; free-runs from reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_lfsr <= 16'hACE1;
        else
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end

    assign w_fill_req = bus.i_rand_fill;
`else
    logic w_unused_rand_fill;

    assign w_unused_rand_fill = bus.i_rand_fill;
    assign w_fill_req         = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_next         = r_state;
        w_clear_word   = 1'b0;
        w_store        = 1'b0;
        w_store_val    = 3'd0;
        w_echo_load    = 1'b0;
        w_echo_cancel  = 1'b0;
        w_write_enable = 1'b0;
        w_game_start   = 1'b0;
        w_busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_fill_req) begin
                    w_next        = S_FILL;
                    w_clear_word  = 1'b1;
                    w_echo_cancel = 1'b1;
                end else if (bus.i_arm) begin
                    w_next       = S_RECORD;
                    w_clear_word = 1'b1;
                end
            end
            S_RECORD: begin
                // Random fill beats clear and keys; clear beats a same-cycle key.
                if (w_fill_req) begin
                    w_next        = S_FILL;
                    w_clear_word  = 1'b1;
                    w_echo_cancel = 1'b1;
                end else if (bus.i_clear) begin
                    w_clear_word  = 1'b1;
                    w_echo_cancel = 1'b1;
                end else if (w_key_ok) begin
                    w_store     = 1'b1;
                    w_store_val = w_note;
                    w_echo_load = 1'b1;
                    if (r_count == LAST_SLOT)
                        w_next = S_WRITE;
                end
            end
            S_FILL: begin
`ifdef MELODY_RANDOM_EN
                w_store     = 1'b1;
                w_store_val = r_lfsr[2:0];
                if (r_count == LAST_SLOT)
                    w_next = S_WRITE;
`else
                w_next = S_IDLE;
`endif
            end
            S_WRITE: begin
                w_write_enable = 1'b1;
                w_next         = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST)
                    w_next = S_START;
            end
            S_START: begin
                w_game_start = 1'b1;
                w_next       = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (bus.i_game_end)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= 32'd0;
            r_count <= 4'd0;
        end else if (w_clear_word) begin
            r_data  <= 32'd0;
            r_count <= 4'd0;
        end else if (w_store) begin
            r_data[{r_count[2:0], 2'b00} +: 4] <= {1'b0, w_store_val};
            r_count                            <= r_count + 4'd1;
        end
    end

    // Runs only while in GAP so an aborted or finished count always restarts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_gap_cnt <= '0;
        else if (r_state == S_GAP)
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        else
            r_gap_cnt <= '0;
    end

    // Echo keeps counting down after recording ends; a new key restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_echo     <= 4'd0;
            r_echo_cnt <= '0;
        end else if (w_echo_cancel) begin
            r_echo     <= 4'd0;
            r_echo_cnt <= '0;
        end else if (w_echo_load) begin
            r_echo     <= bus.i_key_code;
            r_echo_cnt <= ECHO_LOAD;
        end else if (r_echo_cnt != '0) begin
            r_echo_cnt <= r_echo_cnt - ECHO_W'(1);
        end else begin
            r_echo     <= 4'd0;
        end
    end

    assign bus.o_data_out     = r_data;
    assign bus.o_note_count   = r_count;
    assign bus.o_echo_out     = r_echo;
    assign bus.o_write_enable = w_write_enable;
    assign bus.o_game_start   = w_game_start;
    assign bus.o_busy         = w_busy;
endmodule

// File: tb/tb_melody_writer.sv
// Self-checking bench for melody_writer: random melodies against a queue-based model,
// plus directed echo, clear, game-end, reset-abort and (MELODY_RANDOM_EN) random-fill cases.
module tb_melody_writer;
    localparam int NUM_NOTES   = 8;
    localparam int START_GAP   = 16;
    localparam int ECHO_CYCLES = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    melody_if bus();

    melody_writer #(
        .NUM_NOTES  (NUM_NOTES),
        .START_GAP  (START_GAP),
        .ECHO_CYCLES(ECHO_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe monitor, sampled on the falling edge.
    int cyc      = 0;
    int we_cnt   = 0;
    int gs_cnt   = 0;
    int we_cyc   = 0;
    int gs_cyc   = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.o_write_enable === 1'b1) begin
            we_cnt <= we_cnt + 1;
            we_cyc <= cyc;
        end
        if (bus.o_game_start === 1'b1) begin
            gs_cnt <= gs_cnt + 1;
            gs_cyc <= cyc;
        end
        if (bus.o_write_enable === 1'b1 && bus.o_game_start === 1'b1)
            both_cnt <= both_cnt + 1;
    end

`ifdef MELODY_RANDOM_EN
    logic [15:0] m_lfsr;

    always @(posedge clk or posedge reset) begin
        if (reset)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= (m_lfsr >> 1) | (((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
    end
`endif

    // Model: the accepted notes in play order.
    int q[$];
    int we0;
    int gs0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w = 32'd0;
        foreach (q[i])
            w = w + 32'(q[i] - 1) * (32'd1 << (4 * i));
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm = 1'b0;
        q.delete();
        we0 = we_cnt;
        gs0 = gs_cnt;
        check("arm_busy", 32'(bus.o_busy), 32'd1);
        check("arm_count", 32'(bus.o_note_count), 32'd0);
        check("arm_data", bus.o_data_out, 32'd0);
    endtask

    task automatic press(input logic [3:0] code, input logic with_clear);
        bus.i_key_valid = 1'b1;
        bus.i_key_code  = code;
        bus.i_clear     = with_clear;
        tick();
        bus.i_key_valid = 1'b0;
        bus.i_clear     = 1'b0;
        if (with_clear) begin
            q.delete();
            check("clear_echo", 32'(bus.o_echo_out), 32'd0);
        end else if (code >= 4'd1 && code <= 4'd8) begin
            q.push_back(int'(code));
            check("key_echo", 32'(bus.o_echo_out), 32'(code));
        end
        check("rec_count", 32'(bus.o_note_count), 32'(q.size()));
        check("rec_data", bus.o_data_out, model_word());
    endtask

    function automatic logic [3:0] bad_key();
        int r = int'($urandom_range(0, 7));
        return (r == 0) ? 4'd0 : 4'(8 + r);
    endfunction

    task automatic fill_random_notes();
        while (q.size() < NUM_NOTES)
            press(4'($urandom_range(1, 8)), 1'b0);
    endtask

    task automatic finish_melody(input logic [31:0] exp_word);
        int waited = 0;
        while (gs_cnt == gs0 && waited < START_GAP + 20) begin
            tick();
            waited++;
        end
        check("gs_seen", 32'(gs_cnt - gs0), 32'd1);
        check("we_pulses", 32'(we_cnt - we0), 32'd1);
        check("start_spacing", 32'(gs_cyc - we_cyc), 32'(START_GAP + 1));
        check("strobe_overlap", 32'(both_cnt), 32'd0);
        bus.i_game_end = 1'b0;
        repeat (100) tick();
        check("no_extra_strobes", 32'((we_cnt - we0) + (gs_cnt - gs0)), 32'd2);
        check("wait_busy", 32'(bus.o_busy), 32'd1);
        check("wait_data", bus.o_data_out, exp_word);
        bus.i_game_end = 1'b1;
        tick();
        bus.i_game_end = 1'b0;
        check("end_busy", 32'(bus.o_busy), 32'd0);
        check("end_data", bus.o_data_out, exp_word);
    endtask

    task automatic random_melody();
        int r;
        do_arm();
        while (q.size() < NUM_NOTES) begin
            r = int'($urandom_range(0, 19));
            if (r < 2 && q.size() > 0)
                press(4'($urandom_range(1, 8)), 1'b1);
            else if (r < 5)
                press(bad_key(), 1'b0);
            else if (r < 7)
                tick();
            else
                press(4'($urandom_range(1, 8)), 1'b0);
        end
        check("rand_we_now", 32'(bus.o_write_enable), 32'd1);
        finish_melody(model_word());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [31:0] exp_word;
        logic [3:0]  fixed_keys [8] = '{4'd3, 4'd1, 4'd8, 4'd2, 4'd5, 4'd5, 4'd7, 4'd4};

        bus.i_arm       = 1'b0;
        bus.i_key_valid = 1'b0;
        bus.i_key_code  = 4'd0;
        bus.i_clear     = 1'b0;
        bus.i_rand_fill = 1'b0;
        bus.i_game_end  = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_data", bus.o_data_out, 32'd0);
        check("rst_we", 32'(bus.o_write_enable), 32'd0);
        check("rst_gs", 32'(bus.o_game_start), 32'd0);
        check("rst_echo", 32'(bus.o_echo_out), 32'd0);
        check("rst_count", 32'(bus.o_note_count), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);

        // Keys and game_end in IDLE are ignored.
        bus.i_key_valid = 1'b1;
        bus.i_key_code  = 4'd5;
        bus.i_game_end  = 1'b1;
        tick();
        bus.i_key_valid = 1'b0;
        bus.i_game_end  = 1'b0;
        check("idle_count", 32'(bus.o_note_count), 32'd0);
        check("idle_busy", 32'(bus.o_busy), 32'd0);
        check("idle_echo", 32'(bus.o_echo_out), 32'd0);

        // Directed melody 3,1,8,2,5,5,7,4.
        do_arm();
        foreach (fixed_keys[i])
            press(fixed_keys[i], 1'b0);
        check("fixed_word", bus.o_data_out, 32'h36441702);
        check("fixed_count", 32'(bus.o_note_count), 32'd8);
        check("fixed_we_now", 32'(bus.o_write_enable), 32'd1);
        finish_melody(32'h36441702);

        // Invalid keys, echo length, clear priority.
        do_arm();
        bus.i_game_end = 1'b1;
        press(4'd0, 1'b0);
        check("bad0_echo", 32'(bus.o_echo_out), 32'd0);
        press(4'd9, 1'b0);
        press(4'd15, 1'b0);
        check("bad_echo", 32'(bus.o_echo_out), 32'd0);
        check("rec_ignores_end", 32'(bus.o_busy), 32'd1);
        bus.i_game_end = 1'b0;
        press(4'd6, 1'b0);
        bad = 0;
        for (int i = 1; i < ECHO_CYCLES; i++) begin
            tick();
            if (bus.o_echo_out !== 4'd6)
                bad++;
        end
        check("echo_hold", 32'(bad), 32'd0);
        tick();
        check("echo_off", 32'(bus.o_echo_out), 32'd0);
        press(4'd1, 1'b0);
        press(4'd4, 1'b0);
        check("three_notes", 32'(bus.o_note_count), 32'd3);
        press(4'd2, 1'b1);
        check("clear_count", 32'(bus.o_note_count), 32'd0);
        check("clear_data", bus.o_data_out, 32'd0);
        press(4'd2, 1'b0);
        check("slot0_after_clear", 32'(bus.o_data_out[3:0]), 32'd1);
        fill_random_notes();
        check("dir_we_now", 32'(bus.o_write_enable), 32'd1);
        finish_melody(model_word());

        repeat (4) random_melody();

        // Reset in the middle of the GAP count.
        do_arm();
        fill_random_notes();
        repeat (5) tick();
        gs0 = gs_cnt;
        #2 reset = 1'b1;
        #1;
        check("abort_data", bus.o_data_out, 32'd0);
        check("abort_we", 32'(bus.o_write_enable), 32'd0);
        check("abort_gs", 32'(bus.o_game_start), 32'd0);
        check("abort_echo", 32'(bus.o_echo_out), 32'd0);
        check("abort_count", 32'(bus.o_note_count), 32'd0);
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) tick();
        check("abort_no_start", 32'(gs_cnt - gs0), 32'd0);
        check("abort_idle", 32'(bus.o_busy), 32'd0);

`ifdef MELODY_RANDOM_EN
        // Random fill straight after reset, with a competing key press.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.i_rand_fill = 1'b1;
        bus.i_key_valid = 1'b1;
        bus.i_key_code  = 4'd3;
        tick();
        bus.i_rand_fill = 1'b0;
        bus.i_key_valid = 1'b0;
        we0 = we_cnt;
        gs0 = gs_cnt;
        check("fill_busy", 32'(bus.o_busy), 32'd1);
        check("fill_start_count", 32'(bus.o_note_count), 32'd0);
        check("fill_no_echo", 32'(bus.o_echo_out), 32'd0);
        exp_word = 32'd0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            exp_word = exp_word | (32'(m_lfsr & 16'd7) << (4 * i));
            tick();
        end
        check("fill_data", bus.o_data_out, exp_word);
        check("fill_bit3", bus.o_data_out & 32'h88888888, 32'd0);
        check("fill_count", 32'(bus.o_note_count), 32'(NUM_NOTES));
        check("fill_we_now", 32'(bus.o_write_enable), 32'd1);
        finish_melody(exp_word);
`else
        // Without the random feature, rand_fill does nothing.
        bus.i_rand_fill = 1'b1;
        tick();
        bus.i_rand_fill = 1'b0;
        tick();
        check("rand_fill_ignored", 32'(bus.o_busy), 32'd0);
        exp_word = bus.o_data_out;
        check("rand_fill_no_data", exp_word, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
